// File: rtl/lcd_refresh_pkg.sv
// lcd_refresh_pkg
// Shared definitions for the LCD refresh sequencer: FSM state encoding,
// HD44780 command bytes, display character bytes, per-phase beat counts and
// small lookup helpers for the fixed label text and the init command list.
// Optional feature macro used by the importing files: LCD_REFRESH_FREE_COUNT_EN.
package lcd_refresh_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_CLR_WAIT,
        ST_L1,
        ST_L2,
        ST_FIN
    } state_t;

    // HD44780 commands
    localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] CMD_LINE1        = 8'h80;
    localparam logic [7:0] CMD_LINE2        = 8'hC0;

    // Display characters
    localparam logic [7:0] CHAR_HASH  = 8'h23;
    localparam logic [7:0] CHAR_DASH  = 8'h2D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;

    // Beats per phase: init list, and one address command + 16 chars per line
    localparam int unsigned INIT_BEATS   = 4;
    localparam int unsigned CLR_CMD_IDX  = 2;
    localparam int unsigned LINE_BEATS   = 17;
    localparam int unsigned NUM_ROOMS    = 12;

    function automatic logic [7:0] init_cmd(input logic [1:0] sel);
        case (sel)
            2'd0:    return CMD_FUNCTION_SET;
            2'd1:    return CMD_DISPLAY_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY_MODE;
        endcase
    endfunction

    // "OCC:"
    function automatic logic [7:0] occ_label(input logic [1:0] sel);
        case (sel)
            2'd0:    return 8'h4F;
            2'd1:    return 8'h43;
            2'd2:    return 8'h43;
            default: return 8'h3A;
        endcase
    endfunction

    // "FREE:"
    function automatic logic [7:0] free_label(input logic [2:0] sel);
        case (sel)
            3'd0:    return 8'h46;
            3'd1:    return 8'h52;
            3'd2:    return 8'h45;
            3'd3:    return 8'h45;
            default: return 8'h3A;
        endcase
    endfunction

endpackage

// File: rtl/lcd_refresh_sequencer_room_free_counter.sv
// room_free_counter
// Combinational free-room count for the line-2 display: counts the rooms not
// marked occupied in the 12-bit snapshot and renders the count as two ASCII
// decimal digits. Only compiled when LCD_REFRESH_FREE_COUNT_EN is defined.
// Ports:
//   snapshot   in  12  room occupancy, 1 = occupied
//   free_count out  4  number of free rooms, 0..12
//   tens_char  out  8  ASCII tens digit ('0' or '1')
//   ones_char  out  8  ASCII ones digit
`ifdef LCD_REFRESH_FREE_COUNT_EN
module room_free_counter (
    input  logic [11:0] snapshot,
    output logic [3:0]  free_count,
    output logic [7:0]  tens_char,
    output logic [7:0]  ones_char
);
    import lcd_refresh_pkg::*;

    logic [3:0] occupied;
    logic [3:0] ones_val;

    always_comb begin
        occupied = '0;
        for (int unsigned k = 0; k < NUM_ROOMS; k++) begin
            occupied = occupied + {3'b000, snapshot[k]};
        end
        free_count = 4'd12 - occupied;
        if (free_count >= 4'd10) begin
            tens_char = CHAR_ZERO + 8'd1;
            ones_val  = free_count - 4'd10;
        end else begin
            tens_char = CHAR_ZERO;
            ones_val  = free_count;
        end
        ones_char = CHAR_ZERO + {4'b0000, ones_val};
    end

endmodule
`endif

// File: rtl/lcd_refresh_sequencer.sv
// lcd_refresh_sequencer
// Waits for the active-low restart request to be released, snapshots the room
// occupancy flags and streams one complete HD44780 refresh (init commands,
// line 1 occupancy map, optional line 2 free-room count) to the LCD byte
// controller over a valid/ready handshake.
// Optional feature: LCD_REFRESH_FREE_COUNT_EN adds line 2 (38 beats);
// without it the refresh ends after line 1 (21 beats).
// Ports:
//   iCLK        in   1  system clock
//   iRST_N      in   1  asynchronous active-low reset
//   iRESTART_N  in   1  restart request (asynchronous, active-low level)
//   iSTATUS     in  12  room occupancy, bit k = room k+1, 1 = occupied
//   oLCD_DATA   out  9  {RS, byte}, RS=1 for characters
//   oLCD_VALID  out  1  oLCD_DATA valid
//   iLCD_READY  in   1  controller accepts the beat with oLCD_VALID
//   oBUSY       out  1  refresh in progress
//   oDONE       out  1  one-cycle pulse after the last beat is accepted
module lcd_refresh_sequencer #(
    parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iRESTART_N,
    input  logic [11:0] iSTATUS,
    output logic [8:0]  oLCD_DATA,
    output logic        oLCD_VALID,
    input  logic        iLCD_READY,
    output logic        oBUSY,
    output logic        oDONE
);
    import lcd_refresh_pkg::*;

    localparam int unsigned CW = $clog2(CLEAR_WAIT_CYC + 1);

    logic          sync1, sync2, sync_d, rise;
    logic [11:0]   snapshot;
    state_t        state;
    logic [4:0]    idx;
    logic [CW-1:0] cnt;
    logic [8:0]    beat_data;
    logic [1:0]    occ_sel;
    logic [3:0]    room_sel;
    logic          abort;

    // Synchronizer, registered rising-edge detect and snapshot capture.
    // sync_d resets low, so a request already released at reset exit is an edge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync_d   <= 1'b0;
            rise     <= 1'b0;
            snapshot <= '0;
        end else begin
            sync1  <= iRESTART_N;
            sync2  <= sync1;
            sync_d <= sync2;
            rise   <= sync2 & ~sync_d;
            if (sync2 && !sync_d) begin
                snapshot <= iSTATUS;
            end
        end
    end

    assign abort    = oBUSY & ~sync2;
    assign occ_sel  = idx[1:0] - 2'd1;
    assign room_sel = idx[3:0] - 4'd5;

`ifdef LCD_REFRESH_FREE_COUNT_EN
    logic [3:0] free_count;
    logic [7:0] tens_char, ones_char;
    logic [2:0] free_sel;

    assign free_sel = idx[2:0] - 3'd1;

    room_free_counter u_free (
        .snapshot   (snapshot),
        .free_count (free_count),
        .tens_char  (tens_char),
        .ones_char  (ones_char)
    );
`endif

    // Byte for beat idx of the current phase
    always_comb begin
        beat_data = '0;
        case (state)
            ST_INIT: beat_data = {1'b0, init_cmd(idx[1:0])};
            ST_L1: begin
                if (idx == 5'd0)
                    beat_data = {1'b0, CMD_LINE1};
                else if (idx < 5'd5)
                    beat_data = {1'b1, occ_label(occ_sel)};
                else
                    beat_data = {1'b1, snapshot[room_sel] ? CHAR_HASH : CHAR_DASH};
            end
`ifdef LCD_REFRESH_FREE_COUNT_EN
            ST_L2: begin
                if (idx == 5'd0)
                    beat_data = {1'b0, CMD_LINE2};
                else if (idx < 5'd6)
                    beat_data = {1'b1, free_label(free_sel)};
                else if (idx == 5'd6)
                    beat_data = {1'b1, tens_char};
                else if (idx == 5'd7)
                    beat_data = {1'b1, ones_char};
                else
                    beat_data = {1'b1, CHAR_SPACE};
            end
`endif
            default: beat_data = '0;
        endcase
    end

    // Each beat is presented in the cycle after the previous acceptance;
    // a pending beat always completes before an abort takes effect.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            oLCD_DATA  <= '0;
            oLCD_VALID <= 1'b0;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (rise) begin
                        state      <= ST_INIT;
                        idx        <= '0;
                        oLCD_DATA  <= {1'b0, CMD_FUNCTION_SET};
                        oLCD_VALID <= 1'b1;
                        oBUSY      <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (oLCD_VALID && !iLCD_READY) begin
                        // hold the pending beat
                    end else if (abort) begin
                        state      <= ST_IDLE;
                        idx        <= '0;
                        oLCD_VALID <= 1'b0;
                        oBUSY      <= 1'b0;
                    end else if (oLCD_VALID) begin
                        oLCD_VALID <= 1'b0;
                        case (state)
                            ST_INIT: begin
                                if (idx == 5'(CLR_CMD_IDX)) begin
                                    state <= ST_CLR_WAIT;
                                    cnt   <= '0;
                                end else if (idx == 5'(INIT_BEATS - 1)) begin
                                    state <= ST_L1;
                                    idx   <= '0;
                                end else begin
                                    idx <= idx + 5'd1;
                                end
                            end
                            ST_L1: begin
                                if (idx == 5'(LINE_BEATS - 1)) begin
`ifdef LCD_REFRESH_FREE_COUNT_EN
                                    state <= ST_L2;
                                    idx   <= '0;
`else
                                    state <= ST_FIN;
                                    idx   <= '0;
                                    oBUSY <= 1'b0;
                                    oDONE <= 1'b1;
`endif
                                end else begin
                                    idx <= idx + 5'd1;
                                end
                            end
`ifdef LCD_REFRESH_FREE_COUNT_EN
                            ST_L2: begin
                                if (idx == 5'(LINE_BEATS - 1)) begin
                                    state <= ST_FIN;
                                    idx   <= '0;
                                    oBUSY <= 1'b0;
                                    oDONE <= 1'b1;
                                end else begin
                                    idx <= idx + 5'd1;
                                end
                            end
`endif
                            default: state <= ST_IDLE;
                        endcase
                    end else if (state == ST_CLR_WAIT) begin
                        // Last wait cycle presents the entry-mode command directly
                        if (cnt == CW'(CLEAR_WAIT_CYC - 1)) begin
                            state      <= ST_INIT;
                            idx        <= 5'(INIT_BEATS - 1);
                            oLCD_DATA  <= {1'b0, CMD_ENTRY_MODE};
                            oLCD_VALID <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        oLCD_DATA  <= beat_data;
                        oLCD_VALID <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// tb_lcd_refresh_sequencer
// Directed self-checking bench for lcd_refresh_sequencer. Works for both the
// default build and LCD_REFRESH_FREE_COUNT_EN; uses a short clear wait.
module tb_lcd_refresh_sequencer;

    localparam int unsigned CW = 20;
`ifdef LCD_REFRESH_FREE_COUNT_EN
    localparam int NB = 38;
`else
    localparam int NB = 21;
`endif

    logic        iCLK;
    logic        iRST_N;
    logic        iRESTART_N;
    logic [11:0] iSTATUS;
    logic [8:0]  oLCD_DATA;
    logic        oLCD_VALID;
    logic        iLCD_READY;
    logic        oBUSY;
    logic        oDONE;

    int checks = 0;
    int errors = 0;

    lcd_refresh_sequencer #(.CLEAR_WAIT_CYC(CW)) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iRESTART_N (iRESTART_N),
        .iSTATUS    (iSTATUS),
        .oLCD_DATA  (oLCD_DATA),
        .oLCD_VALID (oLCD_VALID),
        .iLCD_READY (iLCD_READY),
        .oBUSY      (oBUSY),
        .oDONE      (oDONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected beat i of a refresh for a given snapshot
    function automatic logic [8:0] exp_beat(input int i, input logic [11:0] st);
        string occ = "OCC:";
        string fr  = "FREE:";
        int    free;
        free = 12 - $countones(st);
        if (i == 0)       return 9'h038;
        else if (i == 1)  return 9'h00C;
        else if (i == 2)  return 9'h001;
        else if (i == 3)  return 9'h006;
        else if (i == 4)  return 9'h080;
        else if (i < 9)   return {1'b1, occ[i-5]};
        else if (i < 21)  return {1'b1, st[i-9] ? 8'h23 : 8'h2D};
        else if (i == 21) return 9'h0C0;
        else if (i < 27)  return {1'b1, fr[i-22]};
        else if (i == 27) return {1'b1, (free >= 10) ? 8'h31 : 8'h30};
        else if (i == 28) return {1'b1, 8'(8'h30 + free % 10)};
        else              return 9'h120;
    endfunction

    // Entered on a falling edge; returns on the falling edge after acceptance
    task automatic get_beat(input int i, input logic [11:0] st, output int waited);
        waited = 0;
        while (!oLCD_VALID && waited < 200) begin
            @(negedge iCLK);
            waited++;
        end
        chk($sformatf("beat%0d_valid", i), {31'b0, oLCD_VALID}, 32'd1);
        chk($sformatf("beat%0d_data", i), {23'b0, oLCD_DATA}, {23'b0, exp_beat(i, st)});
        if (!iLCD_READY) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge iCLK);
                chk($sformatf("hold%0d_valid", c), {31'b0, oLCD_VALID}, 32'd1);
                chk($sformatf("hold%0d_data", c), {23'b0, oLCD_DATA}, 32'h14F);
            end
            iLCD_READY = 1'b1;
        end
        @(negedge iCLK);
        chk($sformatf("beat%0d_gap", i), {31'b0, oLCD_VALID}, 32'd0);
    endtask

    task automatic run_beats(input logic [11:0] st, input int first, input int last,
                             input int hold_idx, input logic [11:0] new_st);
        int w;
        int n;
        for (int i = first; i <= last; i++) begin
            if (i == hold_idx) iLCD_READY = 1'b0;
            get_beat(i, st, w);
            if (i == first) begin
                chk($sformatf("beat%0d_busy", i), {31'b0, oBUSY}, 32'd1);
                iSTATUS = new_st;
            end else begin
                chk($sformatf("beat%0d_spacing", i), w, (i == 3) ? 32'd0 : 32'd1);
            end
            if (i == 2) begin
                n = 0;
                @(negedge iCLK);
                while (!oLCD_VALID && n < int'(CW) + 50) begin
                    n++;
                    @(negedge iCLK);
                end
                chk("clr_wait_len", n, CW - 1);
            end
        end
        if (last == NB - 1) begin
            chk("done_pulse", {31'b0, oDONE}, 32'd1);
            chk("busy_clear", {31'b0, oBUSY}, 32'd0);
            @(negedge iCLK);
            chk("done_single", {31'b0, oDONE}, 32'd0);
        end
    endtask

    task automatic restart_pulse();
        iRESTART_N = 1'b0;
        repeat (4) @(negedge iCLK);
        iRESTART_N = 1'b1;
    endtask

    initial begin
        int n;
        iRST_N     = 1'b0;
        iRESTART_N = 1'b1;
        iLCD_READY = 1'b1;
        iSTATUS    = 12'h000;

        // Reset state
        repeat (3) @(negedge iCLK);
        chk("rst_valid", {31'b0, oLCD_VALID}, 32'd0);
        chk("rst_data",  {23'b0, oLCD_DATA},  32'd0);
        chk("rst_busy",  {31'b0, oBUSY},      32'd0);
        chk("rst_done",  {31'b0, oDONE},      32'd0);

        // Released request at reset exit counts as an edge: valid from N+3
        iRST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge iCLK);
            chk($sformatf("lat%0d_valid", k), {31'b0, oLCD_VALID}, 32'd0);
        end
        @(negedge iCLK);
        chk("lat3_valid", {31'b0, oLCD_VALID}, 32'd1);
        run_beats(12'h000, 0, NB - 1, -1, 12'h000);

        // Rooms 1 and 3 occupied; status scrambled after snapshot; first char held
        iSTATUS = 12'h005;
        restart_pulse();
        run_beats(12'h005, 0, NB - 1, 5, 12'hFFF);

        // Abort with a pending beat on line 1, then full restart
        iSTATUS = 12'h0A5;
        restart_pulse();
        run_beats(12'h0A5, 0, 14, -1, 12'h0A5);
        iLCD_READY = 1'b0;
        n = 0;
        while (!oLCD_VALID && n < 200) begin
            @(negedge iCLK);
            n++;
        end
        chk("abort_beat", {23'b0, oLCD_DATA}, {23'b0, exp_beat(15, 12'h0A5)});
        iRESTART_N = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge iCLK);
            chk($sformatf("abort_hold%0d", k), {22'b0, oLCD_VALID, oBUSY, oLCD_DATA},
                {22'b0, 1'b1, 1'b1, exp_beat(15, 12'h0A5)});
        end
        iLCD_READY = 1'b1;
        @(negedge iCLK);
        chk("abort_idle", {29'b0, oLCD_VALID, oBUSY, oDONE}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge iCLK);
            chk($sformatf("abort_quiet%0d", k), {30'b0, oLCD_VALID, oDONE}, 32'd0);
        end
        iRESTART_N = 1'b1;
        run_beats(12'h0A5, 0, NB - 1, -1, 12'h0A5);

        // Reset mid-refresh clears outputs at once; all-occupied refresh follows
        iSTATUS = 12'hFFF;
        restart_pulse();
        run_beats(12'hFFF, 0, 1, -1, 12'hFFF);
        iRST_N = 1'b0;
        #1;
        chk("midrst_out", {20'b0, oLCD_VALID, oBUSY, oDONE, oLCD_DATA}, 32'd0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        run_beats(12'hFFF, 0, NB - 1, -1, 12'hFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
